// File: rtl/booth_mul_r4.sv
// booth_mul_r4: radix-4 (modified) Booth sequential multiplier, WIDTH-generic.
// Retires two multiplier bits per cycle, so a signed product needs WIDTH/2 cycles.
// Handshake: start (sampled in IDLE), busy (operation in flight), valid (one-cycle
// product pulse). Z is registered and keeps the last product until the next one.
// Optional macro BOOTH_MUL_UNSIGNED_EN adds a tc input: tc=0 selects unsigned
// operands and runs one extra iteration.
module booth_mul_r4 #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
`ifdef BOOTH_MUL_UNSIGNED_EN
  input  logic               tc,
`endif
  input  logic [WIDTH-1:0]   X,
  input  logic [WIDTH-1:0]   Y,
  output logic               busy,
  output logic               valid,
  output logic [2*WIDTH-1:0] Z
);

  localparam int N_ITER = WIDTH / 2;
`ifdef BOOTH_MUL_UNSIGNED_EN
  // Unsigned operands need one more headroom bit in the adder, and the
  // multiplier gets two zero bits on top to feed the extra iteration.
  localparam int AW = WIDTH + 3;
  localparam int MW = WIDTH + 3;
`else
  localparam int AW = WIDTH + 2;
  localparam int MW = WIDTH + 1;
`endif
  localparam int CW = $clog2(N_ITER + 1) + 1;

  if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_width_check
    $error("booth_mul_r4: WIDTH must be even and >= 4");
  end

  typedef enum logic {IDLE, RUN} state_t;

  state_t               state_q;
  logic [AW-1:0]        mcand_q;
  logic [AW-1:0]        acc_q;
  logic [MW-1:0]        m_q;
  logic [CW-1:0]        cnt_q;
  logic                 busy_q, valid_q;
  logic [2*WIDTH-1:0]   z_q;

  logic [AW-1:0]        pp_d, sum_d, acc_d, mcand_d;
  logic [MW-1:0]        m_d, mload_d;
  logic                 cin_d;
  logic [AW+MW-1:0]     shifted_d;
  logic [CW-1:0]        last_d;
  logic [2*WIDTH-1:0]   prod_d;

`ifdef BOOTH_MUL_UNSIGNED_EN
  logic                 tc_q;
  logic                 xe, ye;
  // Operand load values: sign-extend when tc=1, zero-extend otherwise
  always_comb begin
    xe      = tc & X[WIDTH-1];
    ye      = tc & Y[WIDTH-1];
    mcand_d = {{3{xe}}, X};
    mload_d = {{2{ye}}, Y, 1'b0};
  end
`else
  // Operand load values: multiplicand sign-extended, multiplier with the
  // implicit zero below bit 0
  always_comb begin
    mcand_d = {{2{X[WIDTH-1]}}, X};
    mload_d = {Y, 1'b0};
  end
`endif

  // One Booth step: select the partial product from the 3-bit window, add it
  // into the upper half, then arithmetic-shift {acc, multiplier} right by 2
  always_comb begin
    pp_d  = '0;
    cin_d = 1'b0;
    case (m_q[2:0])
      3'b001, 3'b010: pp_d = mcand_q;
      3'b011:         pp_d = {mcand_q[AW-2:0], 1'b0};
      3'b100: begin
        pp_d  = ~{mcand_q[AW-2:0], 1'b0};
        cin_d = 1'b1;
      end
      3'b101, 3'b110: begin
        pp_d  = ~mcand_q;
        cin_d = 1'b1;
      end
      default:        pp_d = '0;
    endcase
    sum_d     = acc_q + pp_d + {{(AW-1){1'b0}}, cin_d};
    shifted_d = $signed({sum_d, m_q}) >>> 2;
    acc_d     = shifted_d[AW+MW-1:MW];
    m_d       = shifted_d[MW-1:0];
  end

  // Final iteration index and where the product sits after the last shift
  always_comb begin
`ifdef BOOTH_MUL_UNSIGNED_EN
    if (tc_q) begin
      last_d = CW'(N_ITER - 1);
      prod_d = {acc_d[WIDTH-1:0], m_d[WIDTH+2:3]};
    end else begin
      last_d = CW'(N_ITER);
      prod_d = {acc_d[WIDTH-3:0], m_d[WIDTH+2:1]};
    end
`else
    last_d = CW'(N_ITER - 1);
    prod_d = {acc_d[WIDTH-1:0], m_d[WIDTH:1]};
`endif
  end

  // Control FSM and datapath registers; outputs are registered here too
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      mcand_q <= '0;
      acc_q   <= '0;
      m_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      z_q     <= '0;
`ifdef BOOTH_MUL_UNSIGNED_EN
      tc_q    <= 1'b1;
`endif
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            mcand_q <= mcand_d;
            m_q     <= mload_d;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
`ifdef BOOTH_MUL_UNSIGNED_EN
            tc_q    <= tc;
`endif
          end
        end
        RUN: begin
          acc_q <= acc_d;
          m_q   <= m_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == last_d) begin
            z_q     <= prod_d;
            valid_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy  = busy_q;
  assign valid = valid_q;
  assign Z     = z_q;

endmodule
